// File: rtl/fetch_queue_pkg.sv
// Shared fetch-queue types: FEID info-bit indices, the queue entry layout and helpers.
package p_hardisc;

  localparam int FEINFO_VALID = 0;
  localparam int FEINFO_BERR  = 1;
  localparam int FEINFO_PERR  = 2;
  localparam int FEINFO_W     = 5;

  typedef struct packed {
    logic        berr;
    logic [1:0]  pred;
    logic [31:0] data;
  } fq_entry_t;

  // Even parity covers the instruction word and its prediction, not the bus-error flag.
  function automatic logic fq_parity(input fq_entry_t e);
    return ^{e.pred, e.data};
  endfunction

  function automatic logic [FEINFO_W-1:0] fe_info(input logic berr, input logic perr);
    logic [FEINFO_W-1:0] info;
    info               = '0;
    info[FEINFO_VALID] = 1'b1;
    info[FEINFO_BERR]  = berr;
    info[FEINFO_PERR]  = perr;
    return info;
  endfunction

endpackage

// File: rtl/fetch_queue_mem.sv
// Fetch-queue entry storage with wrapping read/write pointers.
// With FETCH_QUEUE_PARITY_EN defined, a parity bit is kept per entry and checked on read.
module fetch_queue_mem
  import p_hardisc::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      s_clk_i,
  input  logic      s_resetn_i,
  input  logic      i_flush,
  input  logic      i_wr,
  input  logic      i_rd,
  input  fq_entry_t i_entry,
  output fq_entry_t o_entry,
  output logic      o_perr
);

  localparam int PTR_W = $clog2(DEPTH);

  fq_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;

  // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_wr) r_wptr <= r_wptr + 1'b1;
      if (i_rd) r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge s_clk_i) begin
    if (i_wr) r_mem[r_wptr] <= i_entry;
  end

  assign o_entry = r_mem[r_rptr];

`ifdef FETCH_QUEUE_PARITY_EN
  logic r_par [DEPTH];

  always_ff @(posedge s_clk_i) begin
    if (i_wr) r_par[r_wptr] <= fq_parity(i_entry);
  end

  assign o_perr = r_par[r_rptr] ^ fq_parity(r_mem[r_rptr]);
`else
  assign o_perr = 1'b0;
`endif

endmodule

// File: rtl/fetch_queue.sv
// Fetch queue feeding the FEID register of the ID stage, with empty-queue bypass.
// Optional per-entry parity checking is enabled by defining FETCH_QUEUE_PARITY_EN.
module fetch_queue
  import p_hardisc::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                s_clk_i,
  input  logic                s_resetn_i,
  input  logic                s_flush_i,
  input  logic                s_stall_i,
  input  logic                s_push_i,
  input  logic [31:0]         s_data_i,
  input  logic [1:0]          s_pred_i,
  input  logic                s_berr_i,
  output logic                s_ready_o,
  output logic [FEINFO_W-1:0] s_feid_info_o,
  output logic [31:0]         s_feid_instr_o,
  output logic [1:0]          s_feid_pred_o
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [CNT_W-1:0]    r_count;
  logic [FEINFO_W-1:0] r_info;
  logic [31:0]         r_instr;
  logic [1:0]          r_pred;

  logic      w_accept;
  logic      w_load;
  logic      w_empty;
  logic      w_pop;
  logic      w_bypass;
  logic      w_wr;
  logic      w_perr;
  fq_entry_t w_in;
  fq_entry_t w_head;

  // Ready depends only on the registered count, keeping stall off the ready path.
  assign s_ready_o = r_count < CNT_W'(DEPTH);
  assign w_accept  = s_push_i & s_ready_o & ~s_flush_i;
  assign w_load    = ~s_stall_i | ~r_info[FEINFO_VALID];
  assign w_empty   = (r_count == '0);
  assign w_pop     = w_load & ~w_empty & ~s_flush_i;
  assign w_bypass  = w_load & w_empty & w_accept;
  assign w_wr      = w_accept & ~w_bypass;

  assign w_in = '{berr: s_berr_i, pred: s_pred_i, data: s_data_i};

  fetch_queue_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .s_clk_i    (s_clk_i),
    .s_resetn_i (s_resetn_i),
    .i_flush    (s_flush_i),
    .i_wr       (w_wr),
    .i_rd       (w_pop),
    .i_entry    (w_in),
    .o_entry    (w_head),
    .o_perr     (w_perr)
  );

  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      r_count <= '0;
    end else if (s_flush_i) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(w_wr) - CNT_W'(w_pop);
    end
  end

  // Queue head has priority over bypass so words leave in push order.
  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      r_info  <= '0;
      r_instr <= '0;
      r_pred  <= '0;
    end else if (s_flush_i) begin
      r_info  <= '0;
    end else if (w_load) begin
      if (!w_empty) begin
        r_info  <= fe_info(w_head.berr, w_perr);
        r_instr <= w_head.data;
        r_pred  <= w_head.pred;
      end else if (w_accept) begin
        r_info  <= fe_info(s_berr_i, 1'b0);
        r_instr <= s_data_i;
        r_pred  <= s_pred_i;
      end else begin
        r_info  <= '0;
      end
    end
  end

  assign s_feid_info_o  = r_info;
  assign s_feid_instr_o = r_instr;
  assign s_feid_pred_o  = r_pred;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed vector table, reset/parity sequences, random vs. queue model.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush, stall, push, berr;
  logic [31:0] data;
  logic [1:0]  pred;
  logic        ready;
  logic [4:0]  info;
  logic [31:0] instr;
  logic [1:0]  fpred;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .s_clk_i        (clk),
    .s_resetn_i     (resetn),
    .s_flush_i      (flush),
    .s_stall_i      (stall),
    .s_push_i       (push),
    .s_data_i       (data),
    .s_pred_i       (pred),
    .s_berr_i       (berr),
    .s_ready_o      (ready),
    .s_feid_info_o  (info),
    .s_feid_instr_o (instr),
    .s_feid_pred_o  (fpred)
  );

  typedef struct {
    logic [31:0] d;
    logic [1:0]  p;
    logic        b;
  } ent_t;

  ent_t mq[$];
  bit   fv;
  ent_t fe;

  typedef struct {
    bit          push;
    logic [31:0] d;
    bit          berr;
    bit          stall;
    bit          flush;
    logic [4:0]  ei;
    logic [31:0] einstr;
    bit          er;
  } vec_t;

  vec_t tbl[26];

  function automatic vec_t v(bit pu, logic [31:0] d, bit b, bit st, bit fl,
                             logic [4:0] ei, logic [31:0] ein, bit er);
    vec_t r;
    r = '{pu, d, b, st, fl, ei, ein, er};
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Queue-level model: a FIFO of words plus one FEID slot.
  task automatic model_step(input bit pu, input ent_t e, input bit st, input bit fl);
    bit acc;
    if (fl) begin
      mq.delete();
      fv = 0;
      return;
    end
    acc = pu && (mq.size() < DEPTH);
    if (!st || !fv) begin
      if (mq.size() > 0) begin
        fe = mq.pop_front();
        fv = 1;
        if (acc) mq.push_back(e);
      end else if (acc) begin
        fe = e;
        fv = 1;
      end else begin
        fv = 0;
      end
    end else if (acc) begin
      mq.push_back(e);
    end
  endtask

  task automatic drive(input bit pu, input logic [31:0] d, input logic [1:0] p,
                       input bit b, input bit st, input bit fl);
    push = pu; data = d; pred = p; berr = b; stall = st; flush = fl;
  endtask

  task automatic tick();
    ent_t e;
    @(posedge clk);
    e = '{data, pred, berr};
    model_step(push, e, stall, flush);
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_ready"}, 64'(ready), 64'(mq.size() < DEPTH));
    chk({tag, "_info"}, 64'(info), fv ? 64'({3'b000, fe.b, 1'b1}) : 64'd0);
    if (fv) begin
      chk({tag, "_instr"}, 64'(instr), 64'(fe.d));
      chk({tag, "_pred"}, 64'(fpred), 64'(fe.p));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 resetn = 1'b0;
    mq.delete();
    fv = 0;
    #1;
    chk("async_rst_info", 64'(info), 64'd0);
    chk("async_rst_instr", 64'(instr), 64'd0);
    chk("async_rst_pred", 64'(fpred), 64'd0);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("rst_ready", 64'(ready), 64'd1);
  endtask

  initial begin
    resetn = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    fv = 0;

    tbl[0]  = v(1, 32'h00000013, 0, 0, 0, 5'b00001, 32'h00000013, 1);
    tbl[1]  = v(0, 32'h0,        0, 0, 0, 5'b00000, 32'h0,        1);
    tbl[2]  = v(1, 32'h000000A1, 1, 0, 0, 5'b00011, 32'h000000A1, 1);
    tbl[3]  = v(0, 32'h0,        0, 0, 0, 5'b00000, 32'h0,        1);
    tbl[4]  = v(1, 32'h000000B1, 0, 1, 0, 5'b00001, 32'h000000B1, 1);
    tbl[5]  = v(1, 32'h000000B2, 0, 1, 0, 5'b00001, 32'h000000B1, 1);
    tbl[6]  = v(1, 32'h000000B3, 0, 1, 0, 5'b00001, 32'h000000B1, 1);
    tbl[7]  = v(1, 32'h000000B4, 0, 1, 0, 5'b00001, 32'h000000B1, 1);
    tbl[8]  = v(1, 32'h000000B5, 0, 1, 0, 5'b00001, 32'h000000B1, 0);
    tbl[9]  = v(1, 32'h000000B6, 0, 1, 0, 5'b00001, 32'h000000B1, 0);
    tbl[10] = v(0, 32'h0,        0, 0, 0, 5'b00001, 32'h000000B2, 1);
    tbl[11] = v(0, 32'h0,        0, 0, 0, 5'b00001, 32'h000000B3, 1);
    tbl[12] = v(0, 32'h0,        0, 0, 0, 5'b00001, 32'h000000B4, 1);
    tbl[13] = v(0, 32'h0,        0, 0, 0, 5'b00001, 32'h000000B5, 1);
    tbl[14] = v(0, 32'h0,        0, 0, 0, 5'b00000, 32'h0,        1);
    tbl[15] = v(1, 32'h000000C1, 0, 1, 0, 5'b00001, 32'h000000C1, 1);
    tbl[16] = v(1, 32'h000000C2, 0, 1, 0, 5'b00001, 32'h000000C1, 1);
    tbl[17] = v(1, 32'h000000C3, 0, 1, 0, 5'b00001, 32'h000000C1, 1);
    tbl[18] = v(1, 32'h000000C4, 0, 1, 0, 5'b00001, 32'h000000C1, 1);
    tbl[19] = v(1, 32'h000000C5, 0, 1, 1, 5'b00000, 32'h0,        1);
    tbl[20] = v(0, 32'h0,        0, 0, 0, 5'b00000, 32'h0,        1);
    tbl[21] = v(1, 32'h000000D1, 0, 1, 0, 5'b00001, 32'h000000D1, 1);
    tbl[22] = v(1, 32'h000000D2, 0, 1, 0, 5'b00001, 32'h000000D1, 1);
    tbl[23] = v(1, 32'h000000D3, 0, 0, 0, 5'b00001, 32'h000000D2, 1);
    tbl[24] = v(0, 32'h0,        0, 0, 0, 5'b00001, 32'h000000D3, 1);
    tbl[25] = v(0, 32'h0,        0, 0, 0, 5'b00000, 32'h0,        1);

    #1;
    chk("rst_info", 64'(info), 64'd0);
    chk("rst_instr", 64'(instr), 64'd0);
    chk("rst_pred", 64'(fpred), 64'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("rst_ready", 64'(ready), 64'd1);
    @(negedge clk);

    // Directed vectors: bypass, bus error, fill/drop, drain order, flush, simultaneous pop+push.
    for (int i = 0; i < 26; i++) begin
      drive(tbl[i].push, tbl[i].d, tbl[i].d[1:0], tbl[i].berr, tbl[i].stall, tbl[i].flush);
      tick();
      chk($sformatf("vec%0d_info", i), 64'(info), 64'(tbl[i].ei));
      chk($sformatf("vec%0d_ready", i), 64'(ready), 64'(tbl[i].er));
      if (tbl[i].ei[0]) begin
        chk($sformatf("vec%0d_instr", i), 64'(instr), 64'(tbl[i].einstr));
        chk($sformatf("vec%0d_pred", i), 64'(fpred), 64'(tbl[i].einstr[1:0]));
      end
    end
    drive(0, 0, 0, 0, 0, 0);

    // Reset asserted mid-stall with a push in flight: everything is discarded.
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'hE0 + 32'(i), 2'(i), 0, 1, 0);
      tick();
    end
    drive(1, 32'h000000E3, 2'b01, 0, 1, 0);
    do_reset();
    chk("rstmid_info", 64'(info), 64'd0);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk("rstmid_empty_info", 64'(info), 64'd0);
    chk("rstmid_empty_ready", 64'(ready), 64'd1);

`ifdef FETCH_QUEUE_PARITY_EN
    // Corrupt one stored word; only that entry reports a parity error.
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'h50 + 32'(i), 2'b00, 0, 1, 0);
      tick();
    end
    drive(0, 0, 0, 0, 1, 0);
    dut.u_mem.r_mem[1].data[5] = ~dut.u_mem.r_mem[1].data[5];
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk("par_first", 64'(info), 64'h01);
    tick();
    chk("par_flipped", 64'(info), 64'h05);
    tick();
    chk("par_after", 64'(info), 64'h01);
    tick();
    mq.delete();
    fv = 0;
    tick();
`endif

    // Randomised traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      drive(($urandom % 4) != 0, $urandom, 2'($urandom), ($urandom % 8) == 0,
            ($urandom % 3) == 0, ($urandom % 25) == 0);
      tick();
      check_model($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
